// File: rtl/bsg_link_credit_scheduler.sv
// Round-robin word scheduler in front of the upstream link with credit-based flow control.
// Optional statistics counters are compiled in when BSG_LINK_SCHED_STATS_EN is defined.
module bsg_link_credit_scheduler #(
  parameter int NUM_REQ          = 4,
  parameter int DATA_WIDTH       = 64,
  parameter int CREDITS          = 16,
  parameter int TOKEN_DECIMATION = 8,
  localparam int SRC_W           = $clog2(NUM_REQ),
  localparam int CRED_W          = $clog2(CREDITS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          link_valid_o,
  output logic [DATA_WIDTH-1:0]         link_data_o,
  output logic [SRC_W-1:0]              link_src_o,
  input  logic                          link_ready_i,
  input  logic                          token_i,
  output logic [CRED_W-1:0]             credit_o,
  output logic                          starved_o,
  output logic                          credit_err_o
`ifdef BSG_LINK_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         stat_sent_o,
  output logic [15:0]                   stat_stall_o
`endif
);

  localparam int IW  = SRC_W + 1;
  localparam int CW1 = CRED_W + 1;

  typedef enum logic [1:0] {IDLE, BUSY, STARVED} state_e;

  state_e                state_reg, state_next;
  logic [SRC_W-1:0]      rr_reg;
  logic [SRC_W-1:0]      grant;
  logic [IW-1:0]         idx;
  logic                  load;
  logic [CRED_W-1:0]     credit_reg;
  logic [CW1-1:0]        credit_sum;
  logic                  credit_over;
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [SRC_W-1:0]      src_reg;
  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_word[gi]    = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign req_ready_o[gi] = load & (grant == SRC_W'(gi));
  end

  // Scan downward so the lowest rotated offset with valid set wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_reg} + IW'(k);
      if (idx >= IW'(NUM_REQ)) idx = idx - IW'(NUM_REQ);
      if (req_valid_i[idx[SRC_W-1:0]]) grant = idx[SRC_W-1:0];
    end
  end

  assign load = ~rst & enable_i & (|req_valid_i) & (credit_reg != '0)
              & ((state_reg != BUSY) | link_ready_i);

  // Credit is charged when a word is accepted, not when the link consumes it.
  assign credit_sum  = {1'b0, credit_reg} - CW1'(load)
                     + (token_i ? CW1'(TOKEN_DECIMATION) : CW1'(0));
  assign credit_over = credit_sum > CW1'(CREDITS);

  always_comb begin
    state_next = state_reg;
    if (load)
      state_next = BUSY;
    else if (state_reg == BUSY && !link_ready_i)
      state_next = BUSY;
    else if (enable_i && (|req_valid_i) && credit_reg == '0)
      state_next = STARVED;
    else
      state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      credit_reg <= CRED_W'(CREDITS);
      err_reg    <= 1'b0;
      data_reg   <= '0;
      src_reg    <= '0;
      rr_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      credit_reg <= credit_over ? CRED_W'(CREDITS) : credit_sum[CRED_W-1:0];
      if (credit_over) err_reg <= 1'b1;
      if (load) begin
        data_reg <= req_word[grant];
        src_reg  <= grant;
        rr_reg   <= (grant == SRC_W'(NUM_REQ - 1)) ? '0 : grant + SRC_W'(1);
      end
    end
  end

  assign link_valid_o = (state_reg == BUSY);
  assign link_data_o  = data_reg;
  assign link_src_o   = src_reg;
  assign credit_o     = credit_reg;
  assign starved_o    = (state_reg == STARVED);
  assign credit_err_o = err_reg;

`ifdef BSG_LINK_SCHED_STATS_EN
  logic [15:0] stall_reg;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    logic [15:0] sent_reg;
    always_ff @(posedge clk) begin
      if (rst)                  sent_reg <= '0;
      else if (req_ready_o[gi]) sent_reg <= sent_reg + 16'd1;
    end
    assign stat_sent_o[gi*16 +: 16] = sent_reg;
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_reg <= '0;
    else if (state_reg == STARVED && stall_reg != 16'hFFFF)
      stall_reg <= stall_reg + 16'd1;
  end

  assign stat_stall_o = stall_reg;
`endif

endmodule
